// File: rtl/master_out_port_if.sv
// rtl/master_out_port_if.sv - serial bus handshake and lane signals between master and slave ports
interface master_out_port_if;
    logic master_valid;
    logic slave_ready;
    logic tx_address;
    logic tx_data;

    modport master (
        output master_valid,
        output tx_address,
        output tx_data,
        input  slave_ready
    );

    modport slave (
        input  master_valid,
        input  tx_address,
        input  tx_data,
        output slave_ready
    );
endinterface

// File: rtl/master_out_port.sv
// rtl/master_out_port.sv - master-side serial transmit port: request, handshake, LSB-first shift-out
module master_out_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] address_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    master_out_port_if.master     bus,
    output logic                  busy,
    output logic                  tx_done,
    output logic                  timeout
);

    localparam int              CW         = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_BIT   = CW'(ADDR_WIDTH - 1);
    // Timer counts completed REQ cycles without a handshake.
    localparam logic [7:0]      TIMER_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        TX   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_sr_q, addr_sr_d;
    logic [DATA_WIDTH-1:0] data_sr_q, data_sr_d;
    logic [7:0]            timer_q, timer_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  master_valid_q, master_valid_d;
    logic                  tx_address_q, tx_address_d;
    logic                  tx_data_q, tx_data_d;
    logic                  busy_q, busy_d;
    logic                  tx_done_q, tx_done_d;
    logic                  timeout_q, timeout_d;

    logic timer_expired;
    logic last_bit;

    assign timer_expired = (timer_q == TIMER_LAST);
    assign last_bit      = (cnt_q == LAST_BIT);

    // State register; reset forces IDLE at once, aborting any transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: handshake takes priority over the timeout in the last allowed cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = REQ;
            REQ: begin
                if (bus.slave_ready)    state_d = TX;
                else if (timer_expired) state_d = IDLE;
            end
            TX:      if (last_bit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the datapath and registered outputs; shift registers present bit 0 on the lanes.
    always_comb begin
        addr_sr_d      = addr_sr_q;
        data_sr_d      = data_sr_q;
        timer_d        = timer_q;
        cnt_d          = cnt_q;
        master_valid_d = 1'b0;
        tx_address_d   = 1'b0;
        tx_data_d      = 1'b0;
        busy_d         = 1'b0;
        tx_done_d      = 1'b0;
        timeout_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_sr_d      = address_in;
                    data_sr_d      = data_in;
                    timer_d        = 8'd0;
                    master_valid_d = 1'b1;
                    busy_d         = 1'b1;
                end
            end
            REQ: begin
                if (bus.slave_ready) begin
                    busy_d       = 1'b1;
                    cnt_d        = '0;
                    tx_address_d = addr_sr_q[0];
                    tx_data_d    = data_sr_q[0];
                    addr_sr_d    = addr_sr_q >> 1;
                    data_sr_d    = data_sr_q >> 1;
                end else if (timer_expired) begin
                    timeout_d = 1'b1;
                end else begin
                    busy_d         = 1'b1;
                    master_valid_d = 1'b1;
                    timer_d        = timer_q + 8'd1;
                end
            end
            TX: begin
                if (last_bit) begin
                    tx_done_d = 1'b1;
                end else begin
                    busy_d       = 1'b1;
                    cnt_d        = cnt_q + 1'b1;
                    // Data register fills with zeros, so the data lane idles low past DATA_WIDTH bits.
                    tx_address_d = addr_sr_q[0];
                    tx_data_d    = data_sr_q[0];
                    addr_sr_d    = addr_sr_q >> 1;
                    data_sr_d    = data_sr_q >> 1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers, all cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_sr_q      <= '0;
            data_sr_q      <= '0;
            timer_q        <= 8'd0;
            cnt_q          <= '0;
            master_valid_q <= 1'b0;
            tx_address_q   <= 1'b0;
            tx_data_q      <= 1'b0;
            busy_q         <= 1'b0;
            tx_done_q      <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            addr_sr_q      <= addr_sr_d;
            data_sr_q      <= data_sr_d;
            timer_q        <= timer_d;
            cnt_q          <= cnt_d;
            master_valid_q <= master_valid_d;
            tx_address_q   <= tx_address_d;
            tx_data_q      <= tx_data_d;
            busy_q         <= busy_d;
            tx_done_q      <= tx_done_d;
            timeout_q      <= timeout_d;
        end
    end

    assign bus.master_valid = master_valid_q;
    assign bus.tx_address   = tx_address_q;
    assign bus.tx_data      = tx_data_q;
    assign busy             = busy_q;
    assign tx_done          = tx_done_q;
    assign timeout          = timeout_q;

endmodule

// File: doc/master_out_port.md
# master_out_port

Master-side serial transmit port for the system bus. It latches a 12-bit address and an 8-bit data word from the master core and requests the bus with `master_valid`. It waits for `slave_ready`, then shifts address and data LSB-first on two parallel serial lanes. It pairs with the slave input port, which samples one bit per clock on each lane starting the cycle after the handshake.

## Interface
- `ADDR_WIDTH`, default 12: address bits sent on `tx_address`.
- `DATA_WIDTH`, default 8: data bits sent on `tx_data`; must be ≤ `ADDR_WIDTH`.
- `TIMEOUT`, default 15: maximum number of cycles `master_valid` stays high without a handshake. Range 1..255.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `start` in 1: transfer request from the master core, sampled only in IDLE.
- `address_in` in `ADDR_WIDTH`: address, captured at the accepting edge of `start`.
- `data_in` in `DATA_WIDTH`: data, captured at the same edge.
- `slave_ready` in 1: slave is idle and able to receive.
- `master_valid` out 1: bus request; handshake = `master_valid & slave_ready` at a rising edge.
- `tx_address` out 1: serial address lane.
- `tx_data` out 1: serial data lane.
- `busy` out 1: high in REQ and TX.
- `tx_done` out 1: one-cycle pulse after the last bit.
- `timeout` out 1: one-cycle pulse when a request is abandoned.

## Operation
- FSM states are IDLE, REQ and TX. All outputs are registered.
- **IDLE:** `busy`=0, `master_valid`=0, lanes=0.
  - At an edge with `start`=1: load `address_in`/`data_in` into shift registers, set wait timer=0, go to REQ.
  - `master_valid` and `busy` become 1 from the next cycle.
- **REQ:** `master_valid`=1.
  - At an edge with `slave_ready`=1: go to TX, drop `master_valid`, set bit counter k=0, drive bit 0 of both registers on the lanes.
  - Otherwise increment the timer. The edge that ends the `TIMEOUT`-th valid cycle without a handshake returns to IDLE, pulses `timeout` for one cycle, and clears `master_valid`/`busy`.
- **TX:** the lanes carry bit k during the k-th cycle after the handshake edge (k = 0..`ADDR_WIDTH`-1).
  - `tx_data` carries data bit k for k < `DATA_WIDTH` and 0 afterwards.
  - After the edge where k = `ADDR_WIDTH`-1: go to IDLE, pulse `tx_done`, force both lanes to 0.
- `start` is ignored while `busy`=1. `address_in`/`data_in` changes after capture have no effect on the transfer in flight.
- If `start` is held high during the `tx_done` (or `timeout`) cycle, the next transfer is accepted at the edge that ends that cycle. Back-to-back transfers therefore have one IDLE cycle between them.
- `slave_ready` is ignored outside REQ.
- Reset asserted (`reset`=0) at any time, including mid-TX:
  - State goes to IDLE immediately.
  - Timer, counter and shift registers clear to 0.
  - Every output (`master_valid`, `tx_address`, `tx_data`, `busy`, `tx_done`, `timeout`) is 0.
  - No `tx_done` is produced for the aborted transfer.

## Timing
- Edge E0 accepts `start`. Cycle C1: `master_valid`=1, `busy`=1.
- With `slave_ready`=1 in C1, the handshake is at edge E1. Address bits 0..11 occupy C2..C13 and data bits 0..7 occupy C2..C9. `tx_data`=0 in C10..C13. `tx_done`=1 in C14, with `busy`=0 in C14.
- Minimum latency from `start` edge to `tx_done` is `ADDR_WIDTH`+2 = 14 cycles. Each wait cycle in REQ adds 1.
- The handshake may land in the last allowed cycle (the `TIMEOUT`-th). In that case the handshake wins and no timeout occurs.
- `tx_done` and `timeout` are mutually exclusive and never longer than one cycle.

## Test plan
- **Reset values:** hold `reset`=0 for 3 cycles -> all outputs 0. Release -> IDLE, outputs stay 0 with `start`=0.
- **Basic transfer:** `address_in`=12'hA5C, `data_in`=8'h3B, `start` pulse, `slave_ready`=1 -> `master_valid` high exactly 1 cycle. `tx_address` over C2..C13 = 0,0,1,1,1,0,1,0,0,1,0,1. `tx_data` over C2..C9 = 1,1,0,1,1,1,0,0, then 0. `tx_done` in C14.
- **Wait then timeout:** `slave_ready`=0 for 5 cycles then 1 (TIMEOUT=15) -> `master_valid` high 6 cycles, serialization starts the cycle after the handshake. Repeat with `slave_ready` always 0 -> `master_valid` high exactly 15 cycles, `timeout` pulse 1 cycle, no lane activity.
- **Back-to-back:** `start` held high, addresses 12'h001 then 12'hFFF -> second `master_valid` rises the cycle after the first `tx_done`. `start` pulses during TX are ignored.
- **Reset mid-operation:** assert `reset`=0 when k=6 -> outputs 0 asynchronously, no `tx_done`. After release, a new transfer of 12'h800/8'h80 serializes correctly (address bit 11 = 1 in C13, data bit 7 = 1 in C9).
- **Input stability:** change `address_in`/`data_in` every cycle after capture -> serialized bits match the values captured at the `start` edge.
